// File: rtl/off_delay_gen.sv
// Turn-off delay generator: keeps enable_o high for a tick-counted drain window
// after enable_i falls, then enforces a minimum tick-counted off time.
`timescale 1ns/1ps
module off_delay_gen #(
  parameter int OFF_DELAY_CYCLES = 10,
  parameter int MIN_OFF_CYCLES   = 2,
  parameter int CNT_W =
    ($clog2(((OFF_DELAY_CYCLES > MIN_OFF_CYCLES) ? OFF_DELAY_CYCLES : MIN_OFF_CYCLES) + 1) > 0)
      ? $clog2(((OFF_DELAY_CYCLES > MIN_OFF_CYCLES) ? OFF_DELAY_CYCLES : MIN_OFF_CYCLES) + 1)
      : 1
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             tick_i,
  input  logic             enable_i,
  output logic             enable_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [1:0] {S_OFF, S_ON, S_DRAIN, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] DRAIN_LAST =
    CNT_W'((OFF_DELAY_CYCLES > 0) ? OFF_DELAY_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((MIN_OFF_CYCLES > 0) ? MIN_OFF_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Outputs are assigned alongside each transition so they always match the new state.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state    <= S_OFF;
      enable_o <= 1'b0;
      busy_o   <= 1'b0;
      count_o  <= '0;
    end else begin
      case (state)
        S_OFF: begin
          if (enable_i) begin
            state    <= S_ON;
            enable_o <= 1'b1;
          end
        end
        S_ON: begin
          if (!enable_i) begin
            count_o <= '0;
            if (OFF_DELAY_CYCLES > 0) begin
              state  <= S_DRAIN;
              busy_o <= 1'b1;
            end else if (MIN_OFF_CYCLES > 0) begin
              state    <= S_HOLD;
              enable_o <= 1'b0;
              busy_o   <= 1'b1;
            end else begin
              state    <= S_OFF;
              enable_o <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // A re-request beats a coincident final tick, so enable_o never dips.
          if (enable_i) begin
            state   <= S_ON;
            busy_o  <= 1'b0;
            count_o <= '0;
          end else if (tick_i) begin
            if (count_o == DRAIN_LAST) begin
              enable_o <= 1'b0;
              count_o  <= '0;
              if (MIN_OFF_CYCLES > 0) begin
                state <= S_HOLD;
              end else begin
                state  <= S_OFF;
                busy_o <= 1'b0;
              end
            end else begin
              count_o <= sat_inc(count_o);
            end
          end
        end
        S_HOLD: begin
          if (tick_i) begin
            if (count_o == HOLD_LAST) begin
              state   <= S_OFF;
              busy_o  <= 1'b0;
              count_o <= '0;
            end else begin
              count_o <= sat_inc(count_o);
            end
          end
        end
        default: begin
          state    <= S_OFF;
          enable_o <= 1'b0;
          busy_o   <= 1'b0;
          count_o  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_off_delay_gen.sv
// Bench for off_delay_gen: default build and a zero-delay build driven in lockstep,
// expectations queued per driven cycle and compared after each clock edge.
`timescale 1ns/1ps
module tb_off_delay_gen;

  localparam int OFFD = 10;
  localparam int MINO = 2;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic tick = 1'b0;
  logic en = 1'b0;
  logic en_o, busy_o;
  logic [CW-1:0] cnt_o;
  logic en_z, busy_z;
  logic [0:0] cnt_z;

  always #5 clk = ~clk;

  off_delay_gen dut (
    .clk_i(clk), .arst_ni(arst_n), .tick_i(tick), .enable_i(en),
    .enable_o(en_o), .busy_o(busy_o), .count_o(cnt_o)
  );

  off_delay_gen #(.OFF_DELAY_CYCLES(0), .MIN_OFF_CYCLES(0)) dut_z (
    .clk_i(clk), .arst_ni(arst_n), .tick_i(tick), .enable_i(en),
    .enable_o(en_z), .busy_o(busy_z), .count_o(cnt_z)
  );

  typedef struct {
    logic       en;
    logic       busy;
    logic [3:0] cnt;
    logic       en_z;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int m_state = 0;  // 0 off, 1 on, 2 drain, 3 hold
  int m_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic e, input logic t);
    case (m_state)
      0: if (e) m_state = 1;
      1: if (!e) begin m_state = 2; m_cnt = 0; end
      2: begin
        if (e) begin
          m_state = 1; m_cnt = 0;
        end else if (t) begin
          if (m_cnt == OFFD - 1) begin m_state = 3; m_cnt = 0; end
          else m_cnt++;
        end
      end
      default: begin
        if (t) begin
          if (m_cnt == MINO - 1) begin m_state = 0; m_cnt = 0; end
          else m_cnt++;
        end
      end
    endcase
  endtask

  task automatic compare_out();
    exp_t x;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check_eq("enable", 32'(en_o), 32'(x.en));
      check_eq("busy", 32'(busy_o), 32'(x.busy));
      check_eq("count", 32'(cnt_o), 32'(x.cnt));
      check_eq("z_enable", 32'(en_z), 32'(x.en_z));
      check_eq("z_busy", 32'(busy_z), 32'd0);
      check_eq("z_count", 32'(cnt_z), 32'd0);
    end
  endtask

  task automatic step(input logic e, input logic t);
    exp_t x;
    en = e;
    tick = t;
    model_step(e, t);
    x.en   = (m_state == 1) || (m_state == 2);
    x.busy = (m_state == 2) || (m_state == 3);
    x.cnt  = 4'(m_cnt);
    x.en_z = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    tick = 1'b0;
    compare_out();
  endtask

  task automatic ticks(input logic e, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < gap - 1; j++) step(e, 1'b0);
      step(e, 1'b1);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_en"}, 32'(en_o), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_cnt"}, 32'(cnt_o), 32'd0);
    check_eq({tag, "_zen"}, 32'(en_z), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst");
    arst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0);

    // Enable with one clock latency
    check_eq("en_pre", 32'(en_o), 32'd0);
    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0);

    // Full drain and hold, ticks every 100 clocks
    ticks(1'b0, 12, 100);
    repeat (3) step(1'b0, 1'b0);

    // Abort during drain
    repeat (2) step(1'b1, 1'b0);
    ticks(1'b0, 5, 3);
    step(1'b1, 1'b0);
    check_eq("abort_busy", 32'(busy_o), 32'd0);
    repeat (2) step(1'b1, 1'b0);

    // Re-enable coinciding with the final drain tick
    ticks(1'b0, 9, 3);
    repeat (2) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check_eq("simul_en", 32'(en_o), 32'd1);
    step(1'b1, 1'b0);

    // Re-enable once in HOLD
    ticks(1'b0, 10, 3);
    step(1'b1, 1'b0);
    check_eq("hold_en", 32'(en_o), 32'd0);
    ticks(1'b1, 2, 4);
    repeat (3) step(1'b1, 1'b0);

    // Async reset mid-drain
    ticks(1'b0, 4, 3);
    check_eq("cnt_mid", 32'(cnt_o), 32'd4);
    en = 1'b1;
    #2;
    arst_n = 1'b0;
    #1;
    check_reset_outs("arst");
    m_state = 0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    check_reset_outs("arst_hold");
    arst_n = 1'b1;
    step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0);

    // Random traffic
    e = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) e = ~e;
      step(e, ($urandom_range(2) == 0));
    end
    repeat (3) step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
